// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory handshake: access-size codes,
// responder state encoding and latency limits.
package mem_pkg;

  typedef enum logic [2:0] {
    DM_WORD   = 3'b000,
    DM_HALF   = 3'b001,
    DM_HALF_U = 3'b010,
    DM_BYTE   = 3'b011,
    DM_BYTE_U = 3'b100
  } dm_type_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE,
    ST_DRAIN
  } mem_state_e;

  localparam int LATENCY_MIN = 1;
  localparam int LATENCY_MAX = 15;
  localparam int CNT_W       = 4;

endpackage

// File: rtl/mem_responder_dm_lane_align.sv
// Combinational lane logic: merges a sized store into the old word and
// extracts/extends a sized load from it.
module dm_lane_align
  import mem_pkg::*;
(
  input  logic [2:0]  dm_type_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] old_word_i,
  output logic [31:0] store_word_o,
  output logic [31:0] load_word_o
);

  logic [15:0] half_old;
  logic [7:0]  byte_old;
  logic [4:0]  byte_sh;

  assign half_old = addr_lo_i[1] ? old_word_i[31:16] : old_word_i[15:0];
  assign byte_sh  = {addr_lo_i, 3'b000};
  assign byte_old = old_word_i[byte_sh +: 8];

  // NOTE: every output gets a default first so no path can infer a latch.
  always_comb begin
    store_word_o = wdata_i;
    load_word_o  = old_word_i;
    case (dm_type_i)
      DM_HALF, DM_HALF_U: begin
        store_word_o = addr_lo_i[1] ? {wdata_i[15:0], old_word_i[15:0]}
                                    : {old_word_i[31:16], wdata_i[15:0]};
        load_word_o  = (dm_type_i == DM_HALF) ? {{16{half_old[15]}}, half_old}
                                              : {16'h0000, half_old};
      end
      DM_BYTE, DM_BYTE_U: begin
        store_word_o                = old_word_i;
        store_word_o[byte_sh +: 8]  = wdata_i[7:0];
        load_word_o  = (dm_type_i == DM_BYTE) ? {{24{byte_old[7]}}, byte_old}
                                              : {24'h000000, byte_old};
      end
      default: begin
        store_word_o = wdata_i;
        load_word_o  = old_word_i;
      end
    endcase
  end

endmodule

// File: rtl/mem_responder.sv
// Multi-cycle data-memory responder: accepts one MemRead/MemWrite request,
// waits a fixed latency, performs the sized access and pulses MemReady.
module mem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [2:0]  DMType,
  input  logic [31:0] Address,
  input  logic [31:0] Write_data,
  output logic [31:0] Read_data,
  output logic        MemReady
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(LATENCY - 1);

  mem_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [AW-1:0]    idx_q;
  logic [1:0]       addr_lo_q;
  logic [31:0]      wdata_q;
  logic [2:0]       dm_q;
  logic             is_write_q;
  logic [31:0]      read_data_q;
  logic             accept, access;
  logic [31:0]      store_word, load_word;
  logic [31:0]      mem_q [DEPTH_WORDS];

  // Address bits above the array index alias onto the same words.
  logic unused_addr_hi;
  assign unused_addr_hi = ^Address[31:AW+2];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    accept   = 1'b0;
    access   = 1'b0;
    MemReady = 1'b0;
    case (state_q)
      ST_IDLE: if (MemRead || MemWrite) begin
        accept  = 1'b1;
        cnt_d   = LAT_LOAD;
        state_d = ST_BUSY;
      end
      ST_BUSY: if (cnt_q == '0) begin
        access  = 1'b1;
        state_d = ST_DONE;
      end else begin
        cnt_d = cnt_q - 4'd1;
      end
      ST_DONE: begin
        MemReady = 1'b1;
        state_d  = ST_DRAIN;
      end
      // A level still high here belongs to the request just served.
      ST_DRAIN: if (!MemRead && !MemWrite) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      addr_lo_q   <= '0;
      wdata_q     <= '0;
      dm_q        <= '0;
      is_write_q  <= 1'b0;
      read_data_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        idx_q      <= Address[AW+1:2];
        addr_lo_q  <= Address[1:0];
        wdata_q    <= Write_data;
        dm_q       <= DMType;
        is_write_q <= MemWrite;
      end
      if (access && !is_write_q) read_data_q <= load_word;
    end
  end

  // NOTE: the array has no reset; its contents survive rstn like real RAM.
  always_ff @(posedge clk) begin
    if (access && is_write_q) mem_q[idx_q] <= store_word;
  end

  dm_lane_align u_align (
    .dm_type_i    (dm_q),
    .addr_lo_i    (addr_lo_q),
    .wdata_i      (wdata_q),
    .old_word_i   (mem_q[idx_q]),
    .store_word_o (store_word),
    .load_word_o  (load_word)
  );

  assign Read_data = read_data_q;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder against a byte-addressed reference
// model with directed and randomized requests.
module tb_mem_responder;

  localparam int DEPTH   = 1024;
  localparam int LAT     = 4;
  localparam int AWB     = $clog2(DEPTH) + 2;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        MemRead = 1'b0;
  logic        MemWrite = 1'b0;
  logic [2:0]  DMType = 3'b000;
  logic [31:0] Address = '0;
  logic [31:0] Write_data = '0;
  logic [31:0] Read_data;
  logic        MemReady;

  int checks = 0;
  int errors = 0;

  logic [7:0]  mb [DEPTH*4];
  logic [31:0] rd_model = '0;

  always #5 clk = ~clk;

  mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .DMType     (DMType),
    .Address    (Address),
    .Write_data (Write_data),
    .Read_data  (Read_data),
    .MemReady   (MemReady)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Size/offset of an access as the byte model sees it.
  function automatic void m_shape(input logic [31:0] a, input logic [2:0] dm,
                                  output int off, output int n, output bit sgn);
    case (dm)
      3'd1, 3'd2: begin n = 2; off = a[1] ? 2 : 0; sgn = (dm == 3'd1); end
      3'd3, 3'd4: begin n = 1; off = int'(a[1:0]); sgn = (dm == 3'd3); end
      default:    begin n = 4; off = 0; sgn = 1'b0; end
    endcase
  endfunction

  function automatic void m_store(input logic [31:0] a, input logic [2:0] dm, input logic [31:0] d);
    int base, off, n; bit sgn;
    logic [31:0] dv;
    base = int'((a >> 2) % DEPTH) * 4;
    m_shape(a, dm, off, n, sgn);
    dv = d;
    for (int i = 0; i < n; i++) begin
      mb[base + off + i] = dv[7:0];
      dv = dv >> 8;
    end
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] a, input logic [2:0] dm);
    int base, off, n; bit sgn;
    longint v;
    base = int'((a >> 2) % DEPTH) * 4;
    m_shape(a, dm, off, n, sgn);
    v = 0;
    for (int i = 0; i < n; i++) v = v + (longint'(mb[base + off + i]) << (8 * i));
    if (sgn && v >= (64'sd1 << (8 * n - 1))) v = v - (64'sd1 << (8 * n));
    return v[31:0];
  endfunction

  // Issue one request from a falling edge, check latency/data/single pulse,
  // then keep the request low long enough for the responder to re-arm.
  task automatic do_req(input logic rd, input logic wr, input logic [2:0] dm,
                        input logic [31:0] a, input logic [31:0] d,
                        input int hold, input string tag);
    int cyc, extra;
    logic got;
    MemRead = rd; MemWrite = wr; DMType = dm; Address = a; Write_data = d;
    got = 1'b0; cyc = 0;
    while (!got && cyc < 60) begin
      @(negedge clk);
      cyc++;
      got = MemReady;
    end
    check({tag, "_latency"}, 32'(cyc), 32'(LAT + 1));
    if (wr) m_store(a, dm, d);
    else if (rd) rd_model = m_load(a, dm);
    check({tag, "_rdata"}, Read_data, rd_model);
    extra = 0;
    repeat (hold) begin
      @(negedge clk);
      if (MemReady) extra++;
    end
    MemRead = 1'b0; MemWrite = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (MemReady) extra++;
    end
    check({tag, "_extra_pulses"}, 32'(extra), 32'd0);
  endtask

  initial begin
    logic [31:0] a, d;
    logic [2:0]  dm;
    int op;

    #12;
    check("reset_memready", {31'd0, MemReady}, 32'd0);
    check("reset_rdata", Read_data, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    // Give the words used below known contents.
    for (int w = 0; w < 32; w++) do_req(1'b0, 1'b1, 3'd0, 32'(w * 4), 32'd0, 0, "init");

    do_req(1'b0, 1'b1, 3'd0, 32'h40, 32'hDEADBEEF, 0, "word_wr");
    do_req(1'b1, 1'b0, 3'd0, 32'h40, 32'h0, 0, "word_rd");
    check("word_rd_value", Read_data, 32'hDEADBEEF);

    do_req(1'b0, 1'b1, 3'd0, 32'h40, 32'h0, 0, "clr");
    do_req(1'b0, 1'b1, 3'd3, 32'h41, 32'h80, 0, "byte_wr");
    do_req(1'b1, 1'b0, 3'd0, 32'h40, 32'h0, 0, "byte_word_rd");
    check("byte_word_value", Read_data, 32'h00008000);
    do_req(1'b1, 1'b0, 3'd3, 32'h41, 32'h0, 0, "byte_s_rd");
    check("byte_s_value", Read_data, 32'hFFFFFF80);
    do_req(1'b1, 1'b0, 3'd4, 32'h41, 32'h0, 0, "byte_u_rd");
    check("byte_u_value", Read_data, 32'h00000080);

    do_req(1'b0, 1'b1, 3'd1, 32'h42, 32'h8001, 0, "half_wr");
    do_req(1'b1, 1'b0, 3'd1, 32'h42, 32'h0, 0, "half_s_rd");
    check("half_s_value", Read_data, 32'hFFFF8001);
    do_req(1'b1, 1'b0, 3'd2, 32'h43, 32'h0, 0, "half_u_rd");
    check("half_u_value", Read_data, 32'h00008001);
    do_req(1'b1, 1'b0, 3'd0, 32'h40, 32'h0, 0, "half_word_rd");
    check("half_word_value", Read_data, 32'h80018000);

    // Held request: one pulse only; next request must still see full latency.
    do_req(1'b1, 1'b0, 3'd0, 32'h40, 32'h0, 3, "held_rd");
    do_req(1'b1, 1'b0, 3'd4, 32'h40, 32'h0, 0, "after_held");
    check("after_held_value", Read_data, 32'h00000000);

    do_req(1'b1, 1'b1, 3'd0, 32'h10, 32'h12345678, 0, "both_high");
    do_req(1'b1, 1'b0, 3'd0, 32'h10, 32'h0, 0, "both_rd");
    check("both_value", Read_data, 32'h12345678);
    do_req(1'b1, 1'b0, 3'd0, 32'h10 + 4 * DEPTH, 32'h0, 0, "wrap_rd");
    check("wrap_value", Read_data, 32'h12345678);

    // Reset in the middle of a write must abandon it.
    do_req(1'b0, 1'b1, 3'd0, 32'h20, 32'h11111111, 0, "pre_rst_wr");
    MemWrite = 1'b1; DMType = 3'd0; Address = 32'h20; Write_data = 32'h22222222;
    repeat (2) @(negedge clk);
    rstn = 1'b0; MemWrite = 1'b0;
    rd_model = '0;
    @(negedge clk);
    check("rst_mid_memready", {31'd0, MemReady}, 32'd0);
    check("rst_mid_rdata", Read_data, 32'd0);
    rstn = 1'b1;
    op = 0;
    repeat (6) begin
      @(negedge clk);
      if (MemReady) op++;
    end
    check("rst_no_pulse", 32'(op), 32'd0);
    do_req(1'b1, 1'b0, 3'd0, 32'h20, 32'h0, 0, "post_rst_rd");
    check("post_rst_value", Read_data, 32'h11111111);

    // Randomized mix over the initialised words, with aliased high bits.
    for (int i = 0; i < 60; i++) begin
      a  = 32'($urandom_range(0, 127)) | (32'($urandom_range(0, 7)) << AWB);
      d  = $urandom;
      dm = 3'($urandom_range(0, 7));
      op = $urandom_range(0, 3);
      case (op)
        0, 1: do_req(1'b1, 1'b0, dm, a, d, $urandom_range(0, 2), "rnd_rd");
        2:    do_req(1'b0, 1'b1, dm, a, d, $urandom_range(0, 2), "rnd_wr");
        default: do_req(1'b1, 1'b1, dm, a, d, 0, "rnd_both");
      endcase
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
